// File: rtl/rate_hex_counter_pkg.sv
// rate_hex_counter_pkg: speed encodings and divider reload helper shared by the rate counter files
package rate_hex_counter_pkg;
   typedef enum logic [1:0] {SPD_FULL = 2'b00, SPD_1HZ = 2'b01, SPD_HALF = 2'b10, SPD_QUARTER = 2'b11} speed_e;
   function automatic int reload(input logic [1:0] s, input int hz);
      return s == SPD_FULL ? 0 : s == SPD_1HZ ? hz - 1 : s == SPD_HALF ? 2 * hz - 1 : 4 * hz - 1;
   endfunction
endpackage

// File: rtl/rate_hex_counter_if.sv
// rate_hex_counter_if: control inputs (enable, speed, par_load, load_val) and outputs (count, tick) of the rate counter
interface rate_hex_counter_if;
   import rate_hex_counter_pkg::*;
   logic       enable;
   logic [1:0] speed;
   logic       par_load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       tick;
   modport master (output enable, speed, par_load, load_val, input count, tick);
   modport slave (input enable, speed, par_load, load_val, output count, tick);
endinterface

// File: rtl/rate_divider.sv
// rate_divider: reloadable down-counter with speed-change detect; ports clock, reset, enable, par_load, speed in, tick out
module rate_divider
   import rate_hex_counter_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       par_load,
   input  logic [1:0] speed,
   output logic       tick
);
   localparam int W = $clog2(4 * CLK_HZ);
   logic [W-1:0] div, rl;
   logic [31:0]  r32;
   logic [1:0]   spd_q;
   logic         zero, chg;
   always_comb begin
      r32  = reload(speed, CLK_HZ);
      rl   = r32[W-1:0];
      zero = div == '0;
      chg  = speed != spd_q;
      tick = enable & zero & ~par_load & ~reset & ~chg;
   end
   always_ff @(posedge clock)
      if (reset || par_load || chg) begin
         div   <= rl;
         spd_q <= speed;
      end else if (enable) div <= zero ? rl : div - W'(1);
endmodule

// File: rtl/rate_hex_counter.sv
// rate_hex_counter: hex digit counter advanced at a selectable rate; ports clock, reset, bus (enable, speed, par_load, load_val, count, tick)
module rate_hex_counter
   import rate_hex_counter_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input logic               clock,
   input logic               reset,
   rate_hex_counter_if.slave bus
);
   logic       tick;
   logic [3:0] cnt;
   rate_divider #(.CLK_HZ(CLK_HZ)) u_div (
      .clock    (clock),
      .reset    (reset),
      .enable   (bus.enable),
      .par_load (bus.par_load),
      .speed    (bus.speed),
      .tick     (tick)
   );
   always_ff @(posedge clock)
      cnt <= reset ? 4'h0 : bus.par_load ? bus.load_val : tick ? cnt + 4'h1 : cnt;
   assign bus.count = cnt;
   assign bus.tick  = tick;
endmodule

// File: tb/tb_rate_hex_counter.sv
// tb_rate_hex_counter: vector table, directed corner sequences and random stimulus against a phase-based reference model
module tb_rate_hex_counter;
   localparam int HZ = 4;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;
   rate_hex_counter_if bus ();
   rate_hex_counter #(.CLK_HZ(HZ)) dut (.clock(clock), .reset(reset), .bus(bus));
   int total = 0, bad = 0;
   int m_cnt = 0, m_ph = 0, m_spd = 0;
   bit m_ok = 1'b0;
   logic t;
   logic [3:0] c;
   typedef struct {
      logic r, e;
      logic [1:0] s;
      logic p;
      logic [3:0] l;
      logic t;
      logic [3:0] c;
   } vec_t;
   vec_t tv[21];
   function automatic int period(input int s);
      int p[4] = '{1, HZ, 2 * HZ, 4 * HZ};
      return p[s];
   endfunction
   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", n, a, x);
      end
   endtask
   task automatic cyc(input logic r, input logic e, input logic [1:0] s, input logic p, input logic [3:0] l,
                      output logic to, output logic [3:0] co);
      logic et;
      @(negedge clock);
      reset = r; bus.enable = e; bus.speed = s; bus.par_load = p; bus.load_val = l;
      #1;
      to = bus.tick;
      co = bus.count;
      et = !r && e && !p && int'(s) == m_spd && m_ph == period(m_spd) - 1;
      if (m_ok) begin
         chk("model_count", 8'(co), 8'(m_cnt));
         chk("model_tick", 8'(to), 8'(et));
      end
      @(posedge clock);
      if (r || p) begin
         m_cnt = r ? 0 : int'(l);
         m_ph  = 0;
         m_spd = int'(s);
         if (r) m_ok = 1'b1;
      end else if (int'(s) != m_spd) begin
         m_ph  = 0;
         m_spd = int'(s);
      end else if (e) begin
         if (m_ph == period(m_spd) - 1) begin
            m_ph  = 0;
            m_cnt = (m_cnt + 1) % 16;
         end else m_ph++;
      end
   endtask
   initial begin
      logic r, e, p;
      logic [1:0] s;
      logic [3:0] l;
      int n;
      tv[0]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 4'h0};
      tv[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 4'h0};
      tv[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 4'h0};
      tv[3]  = '{1'b0, 1'b1, 2'd1, 1'b1, 4'hE, 1'b0, 4'h0};
      tv[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 4'hE};
      tv[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 4'hE};
      tv[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 4'hE};
      tv[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b1, 4'hE};
      tv[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 4'hF};
      tv[9]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 4'hF};
      tv[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 4'hF};
      tv[11] = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b1, 4'hF};
      tv[12] = '{1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 4'h0};
      tv[13] = '{1'b0, 1'b0, 2'd1, 1'b0, 4'h0, 1'b0, 4'h0};
      tv[14] = '{1'b0, 1'b1, 2'd2, 1'b0, 4'h0, 1'b0, 4'h0};
      tv[15] = '{1'b0, 1'b1, 2'd2, 1'b0, 4'h0, 1'b0, 4'h0};
      tv[16] = '{1'b1, 1'b1, 2'd0, 1'b1, 4'h9, 1'b0, 4'h0};
      tv[17] = '{1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 1'b1, 4'h0};
      tv[18] = '{1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 1'b1, 4'h1};
      tv[19] = '{1'b1, 1'b1, 2'd0, 1'b1, 4'h5, 1'b0, 4'h2};
      tv[20] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 4'h0};
      reset = 1'b1; bus.enable = 1'b0; bus.speed = 2'd0; bus.par_load = 1'b0; bus.load_val = 4'h0;
      cyc(1'b1, 1'b0, 2'd1, 1'b0, 4'h0, t, c);
      cyc(1'b0, 1'b0, 2'd1, 1'b0, 4'h0, t, c);
      chk("reset_count", 8'(c), 8'h0);
      chk("reset_tick", 8'(t), 8'h0);
      for (int i = 0; i < 21; i++) begin
         cyc(tv[i].r, tv[i].e, tv[i].s, tv[i].p, tv[i].l, t, c);
         chk($sformatf("vec%0d_tick", i), 8'(t), 8'(tv[i].t));
         chk($sformatf("vec%0d_count", i), 8'(c), 8'(tv[i].c));
      end
      cyc(1'b1, 1'b1, 2'd1, 1'b1, 4'h7, t, c);
      chk("rst_over_load_tick", 8'(t), 8'h0);
      for (int i = 1; i <= 20; i++) begin
         cyc(1'b0, 1'b1, 2'd1, 1'b0, 4'h0, t, c);
         chk($sformatf("hz1_tick%0d", i), 8'(t), 8'(i % 4 == 0));
      end
      cyc(1'b0, 1'b0, 2'd1, 1'b0, 4'h0, t, c);
      chk("hz1_count", 8'(c), 8'h5);
      cyc(1'b1, 1'b1, 2'd0, 1'b0, 4'h0, t, c);
      for (int i = 1; i <= 18; i++) begin
         cyc(1'b0, 1'b1, 2'd0, 1'b0, 4'h0, t, c);
         chk($sformatf("full_tick%0d", i), 8'(t), 8'h1);
         chk($sformatf("full_count%0d", i), 8'(c), 8'((i - 1) % 16));
      end
      cyc(1'b0, 1'b0, 2'd0, 1'b0, 4'h0, t, c);
      chk("full_wrap_count", 8'(c), 8'h2);
      cyc(1'b1, 1'b0, 2'd3, 1'b0, 4'h0, t, c);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 2'd3, 1'b0, 4'h0, t, c);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0, 2'd3, 1'b0, 4'h0, t, c);
         chk("hold_tick", 8'(t), 8'h0);
      end
      n = 0;
      do begin
         cyc(1'b0, 1'b1, 2'd3, 1'b0, 4'h0, t, c);
         n++;
      end while (!t && n < 30);
      chk("hold_gap", 8'(n), 8'd10);
      cyc(1'b0, 1'b0, 2'd3, 1'b0, 4'h0, t, c);
      chk("hold_count", 8'(c), 8'h1);
      cyc(1'b1, 1'b0, 2'd2, 1'b0, 4'h0, t, c);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'd2, 1'b0, 4'h0, t, c);
      cyc(1'b0, 1'b1, 2'd1, 1'b0, 4'h0, t, c);
      chk("spdchg_tick", 8'(t), 8'h0);
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 1'b1, 2'd1, 1'b0, 4'h0, t, c);
         chk($sformatf("spdchg_after%0d", i), 8'(t), 8'(i == 4));
      end
      cyc(1'b1, 1'b0, 2'd1, 1'b0, 4'h0, t, c);
      cyc(1'b0, 1'b0, 2'd1, 1'b1, 4'h9, t, c);
      cyc(1'b0, 1'b1, 2'd1, 1'b0, 4'h0, t, c);
      chk("midrst_pre_count", 8'(c), 8'h9);
      cyc(1'b0, 1'b1, 2'd1, 1'b0, 4'h0, t, c);
      cyc(1'b1, 1'b1, 2'd1, 1'b1, 4'h3, t, c);
      chk("midrst_tick", 8'(t), 8'h0);
      cyc(1'b0, 1'b1, 2'd1, 1'b0, 4'h0, t, c);
      chk("midrst_count", 8'(c), 8'h0);
      chk("midrst_tick_after", 8'(t), 8'h0);
      s = 2'd1;
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 31) == 0;
         e = $urandom_range(0, 3) != 0;
         p = $urandom_range(0, 15) == 0;
         l = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) s = 2'($urandom_range(0, 3));
         cyc(r, e, s, p, l, t, c);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
